// File: rtl/key_event_ctrl.sv
// Game-control front end: turns decoder key/level pairs into press/release events,
// tracks held keys and runs the IDLE/RUN/PAUSED/OVER FSM with rate-limited flaps.
//
// state  | meaning
// IDLE   | waiting for a go press (SPACE/UP) to start a game
// RUN    | game active; flaps accepted once the gap timer has expired
// PAUSED | game frozen; DOWN or SPACE resumes, gap timer held
// OVER   | collision seen; SPACE restarts after the hold timer expires

`ifndef KEY_EVENT_CODES_DEFINED
`define KEY_EVENT_CODES_DEFINED
`define KeyR      [7:0]
`define KEY_UP    8'h75
`define KEY_DOWN  8'h72
`define KEY_LEFT  8'h6B
`define KEY_RIGHT 8'h74
`define KEY_SPACE 8'h29
`define NO_KEY    8'h00
`endif

module key_event_ctrl #(
   parameter int FLAP_GAP  = 2_500_000,
   parameter int OVER_HOLD = 50_000_000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic `KeyR  key,
   input  logic        key_state,
   input  logic        game_over,
   output logic [4:0]  held,
   output logic        flap,
   output logic        start,
   output logic        restart,
   output logic        paused,
   output logic        running,
   output logic [1:0]  state
);

   localparam int GW = $clog2(FLAP_GAP + 1);
   localparam int HW = $clog2(OVER_HOLD + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_PAUSED = 2'd2;
   localparam logic [1:0] S_OVER   = 2'd3;

   logic `KeyR     r_prev_key;
   logic           r_prev_ks;
   logic [4:0]     r_held;
   logic [1:0]     r_state;
   logic [GW-1:0]  r_gap;
   logic [HW-1:0]  r_hold;
   logic           r_flap;
   logic           r_start;
   logic           r_restart;
   logic           r_paused;
   logic           r_running;

   logic           w_event;
   logic           w_press;
   logic           w_release;
   logic           w_go_press;
   logic [4:0]     w_bit;
   logic [4:0]     w_held_nxt;
   logic [1:0]     w_state_nxt;
   logic [GW-1:0]  w_gap_nxt;
   logic [HW-1:0]  w_hold_nxt;
   logic           w_flap_nxt;
   logic           w_start_nxt;
   logic           w_restart_nxt;

   // Typematic repeats present the same pair, so they never count as an event.
   assign w_event    = (key != `NO_KEY) && ({key, key_state} != {r_prev_key, r_prev_ks});
   assign w_press    = w_event && key_state;
   assign w_release  = w_event && !key_state;
   assign w_go_press = w_press && ((key == `KEY_SPACE) || (key == `KEY_UP));

   always_comb begin
      w_bit = 5'b00000;
      case (key)
         `KEY_UP:    w_bit = 5'b00001;
         `KEY_DOWN:  w_bit = 5'b00010;
         `KEY_LEFT:  w_bit = 5'b00100;
         `KEY_RIGHT: w_bit = 5'b01000;
         `KEY_SPACE: w_bit = 5'b10000;
         default:    w_bit = 5'b00000;
      endcase
   end

   always_comb begin
      w_held_nxt = r_held;
      if (w_press)
         w_held_nxt = r_held | w_bit;
      else if (w_release)
         w_held_nxt = r_held & ~w_bit;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_gap_nxt     = r_gap;
      w_hold_nxt    = r_hold;
      w_flap_nxt    = 1'b0;
      w_start_nxt   = 1'b0;
      w_restart_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_go_press) begin
               w_state_nxt = S_RUN;
               w_start_nxt = 1'b1;
               w_flap_nxt  = 1'b1;
               w_gap_nxt   = GW'(FLAP_GAP);
            end
         end
         S_RUN: begin
            if (game_over) begin
               w_state_nxt = S_OVER;
               w_hold_nxt  = HW'(OVER_HOLD);
               w_gap_nxt   = '0;
            end else begin
               if (r_gap != '0)
                  w_gap_nxt = r_gap - 1'b1;
               if (w_press && (key == `KEY_DOWN))
                  w_state_nxt = S_PAUSED;
               else if (w_go_press && (r_gap == '0)) begin
                  w_flap_nxt = 1'b1;
                  w_gap_nxt  = GW'(FLAP_GAP);
               end
            end
         end
         S_PAUSED: begin
            if (w_press && ((key == `KEY_DOWN) || (key == `KEY_SPACE)))
               w_state_nxt = S_RUN;
         end
         S_OVER: begin
            if (r_hold != '0)
               w_hold_nxt = r_hold - 1'b1;
            if (w_press && (key == `KEY_SPACE) && (r_hold == '0)) begin
               w_state_nxt   = S_IDLE;
               w_restart_nxt = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_prev_key <= `NO_KEY;
         r_prev_ks  <= 1'b0;
         r_held     <= '0;
         r_state    <= S_IDLE;
         r_gap      <= '0;
         r_hold     <= '0;
         r_flap     <= 1'b0;
         r_start    <= 1'b0;
         r_restart  <= 1'b0;
         r_paused   <= 1'b0;
         r_running  <= 1'b0;
      end else begin
         r_prev_key <= key;
         r_prev_ks  <= key_state;
         r_held     <= w_held_nxt;
         r_state    <= w_state_nxt;
         r_gap      <= w_gap_nxt;
         r_hold     <= w_hold_nxt;
         r_flap     <= w_flap_nxt;
         r_start    <= w_start_nxt;
         r_restart  <= w_restart_nxt;
         r_paused   <= (w_state_nxt == S_PAUSED);
         r_running  <= (w_state_nxt == S_RUN);
      end
   end

   assign held    = r_held;
   assign flap    = r_flap;
   assign start   = r_start;
   assign restart = r_restart;
   assign paused  = r_paused;
   assign running = r_running;
   assign state   = r_state;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with short timers; each step queues the
// expected registered outputs and pops them after the sampling edge.

`ifndef KEY_EVENT_CODES_DEFINED
`define KEY_EVENT_CODES_DEFINED
`define KeyR      [7:0]
`define KEY_UP    8'h75
`define KEY_DOWN  8'h72
`define KEY_LEFT  8'h6B
`define KEY_RIGHT 8'h74
`define KEY_SPACE 8'h29
`define NO_KEY    8'h00
`endif

module tb_key_event_ctrl;

   localparam logic [7:0] K_UP = `KEY_UP;
   localparam logic [7:0] K_DN = `KEY_DOWN;
   localparam logic [7:0] K_LT = `KEY_LEFT;
   localparam logic [7:0] K_RT = `KEY_RIGHT;
   localparam logic [7:0] K_SP = `KEY_SPACE;
   localparam logic [7:0] K_NO = `NO_KEY;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [7:0]  key = `NO_KEY;
   logic        key_state = 1'b0;
   logic        game_over = 1'b0;
   logic [4:0]  held;
   logic        flap, start, restart, paused, running;
   logic [1:0]  state;

   int n_chk  = 0;
   int n_pass = 0;
   logic [11:0] q_exp[$];
   string       q_tag[$];

   key_event_ctrl #(.FLAP_GAP(8), .OVER_HOLD(16)) dut (
      .clk(clk), .rstn(rstn), .key(key), .key_state(key_state),
      .game_over(game_over), .held(held), .flap(flap), .start(start),
      .restart(restart), .paused(paused), .running(running), .state(state)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] pack_exp(input logic [1:0] st, input logic fl,
                                            input logic sa, input logic rs,
                                            input logic [4:0] hd);
      return {hd, fl, sa, rs, (st == 2'd2), (st == 2'd1), st};
   endfunction

   task automatic check(input string tag, input logic [11:0] exp);
      logic [11:0] obs;
      obs = {held, flap, start, restart, paused, running, state};
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got {held,flap,start,restart,paused,running,state}=%b expected %b",
                  tag, obs, exp);
   endtask

   // Drive one input pair, then compare the outputs registered on the next edge.
   task automatic step(input string tag, input logic [7:0] k, input logic ks,
                       input logic go, input logic [1:0] st, input logic fl,
                       input logic sa, input logic rs, input logic [4:0] hd);
      key       = k;
      key_state = ks;
      game_over = go;
      q_exp.push_back(pack_exp(st, fl, sa, rs, hd));
      q_tag.push_back(tag);
      @(posedge clk);
      #1;
      check(q_tag.pop_front(), q_exp.pop_front());
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset", 12'd0);
      rstn = 1'b1;
      step("idle_after_reset", K_NO, 0, 0, 0, 0, 0, 0, 5'b00000);

      step("start_space", K_SP, 1, 0, 1, 1, 1, 0, 5'b10000);
      for (int i = 0; i < 10; i++)
         step("typematic_hold", K_SP, 1, 0, 1, 0, 0, 0, 5'b10000);
      step("space_release", K_SP, 0, 0, 1, 0, 0, 0, 5'b00000);

      step("flap_gap_expired", K_SP, 1, 0, 1, 1, 0, 0, 5'b10000);
      step("rel_a", K_SP, 0, 0, 1, 0, 0, 0, 5'b00000);
      repeat (2) step("wait_a", K_NO, 0, 0, 1, 0, 0, 0, 5'b00000);
      step("flap_dropped_4", K_SP, 1, 0, 1, 0, 0, 0, 5'b10000);
      step("rel_b", K_SP, 0, 0, 1, 0, 0, 0, 5'b00000);
      repeat (4) step("wait_b", K_NO, 0, 0, 1, 0, 0, 0, 5'b00000);
      step("flap_ok_10", K_SP, 1, 0, 1, 1, 0, 0, 5'b10000);
      step("rel_c", K_SP, 0, 0, 1, 0, 0, 0, 5'b00000);
      repeat (6) step("wait_c", K_NO, 0, 0, 1, 0, 0, 0, 5'b00000);
      step("flap_dropped_8", K_SP, 1, 0, 1, 0, 0, 0, 5'b10000);
      step("rel_d", K_SP, 0, 0, 1, 0, 0, 0, 5'b00000);
      step("flap_ok_10b", K_SP, 1, 0, 1, 1, 0, 0, 5'b10000);
      step("rel_e", K_SP, 0, 0, 1, 0, 0, 0, 5'b00000);

      step("pause_down", K_DN, 1, 0, 2, 0, 0, 0, 5'b00010);
      step("pause_down_rel", K_DN, 0, 0, 2, 0, 0, 0, 5'b00000);
      repeat (8) step("pause_ignores_over", K_NO, 0, 1, 2, 0, 0, 0, 5'b00000);
      step("resume_no_flap", K_SP, 1, 0, 1, 0, 0, 0, 5'b10000);
      step("rel_f", K_SP, 0, 0, 1, 0, 0, 0, 5'b00000);
      step("wait_f", K_NO, 0, 0, 1, 0, 0, 0, 5'b00000);
      step("gap_frozen_drop", K_SP, 1, 0, 1, 0, 0, 0, 5'b10000);
      step("rel_g", K_SP, 0, 0, 1, 0, 0, 0, 5'b00000);
      repeat (4) step("wait_g", K_NO, 0, 0, 1, 0, 0, 0, 5'b00000);
      step("flap_after_resume", K_SP, 1, 0, 1, 1, 0, 0, 5'b10000);
      step("rel_h", K_SP, 0, 0, 1, 0, 0, 0, 5'b00000);

      step("over_beats_flap", K_SP, 1, 1, 3, 0, 0, 0, 5'b10000);
      step("over_rel", K_SP, 0, 0, 3, 0, 0, 0, 5'b00000);
      repeat (3) step("over_wait_a", K_NO, 0, 0, 3, 0, 0, 0, 5'b00000);
      step("over_press_early", K_SP, 1, 0, 3, 0, 0, 0, 5'b10000);
      step("over_rel_b", K_SP, 0, 0, 3, 0, 0, 0, 5'b00000);
      repeat (9) step("over_wait_b", K_NO, 0, 0, 3, 0, 0, 0, 5'b00000);
      step("over_press_hold1", K_SP, 1, 0, 3, 0, 0, 0, 5'b10000);
      step("over_rel_c", K_SP, 0, 0, 3, 0, 0, 0, 5'b00000);
      step("restart", K_SP, 1, 0, 0, 0, 0, 1, 5'b10000);
      step("idle_rel", K_SP, 0, 0, 0, 0, 0, 0, 5'b00000);

      step("start_up_with_over", K_UP, 1, 1, 1, 1, 1, 0, 5'b00001);
      step("held_left", K_LT, 1, 0, 1, 0, 0, 0, 5'b00101);
      step("held_right", K_RT, 1, 0, 1, 0, 0, 0, 5'b01101);
      step("held_repeat", K_RT, 1, 0, 1, 0, 0, 0, 5'b01101);

      #3;
      rstn = 1'b0;
      #1;
      check("async_reset", 12'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      step("post_reset_right", K_RT, 1, 0, 0, 0, 0, 0, 5'b01000);
      step("post_reset_repeat", K_RT, 1, 0, 0, 0, 0, 0, 5'b01000);
      step("post_reset_start", K_SP, 1, 0, 1, 1, 1, 0, 5'b11000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
